// File: rtl/sysx_job_scheduler_if.sv
// Requester/bus-side signal bundle for sysx_job_scheduler.
// slave: scheduler side; master: the requesters plus the sysX master data return.
interface sysx_job_scheduler_if;
    logic [1:0]  iReq;
    logic [3:0]  iSelect;
    logic [1:0]  iReceive;
    logic [63:0] iData;
    logic [11:0] iClockStep;
    logic [1:0]  oGrant;
    logic [1:0]  oDone;
    logic [31:0] oResult;
    logic        oTimeout;
    logic        oBusy;
    logic [3:0]  oAddress;
    logic [31:0] oDataOut;
    logic [31:0] iDataIn;
    logic        oWrite;
    logic        oEnable;

    modport slave (
        input  iReq, iSelect, iReceive, iData, iClockStep, iDataIn,
        output oGrant, oDone, oResult, oTimeout, oBusy, oAddress, oDataOut, oWrite, oEnable
    );

    modport master (
        output iReq, iSelect, iReceive, iData, iClockStep, iDataIn,
        input  oGrant, oDone, oResult, oTimeout, oBusy, oAddress, oDataOut, oWrite, oEnable
    );
endinterface

// File: rtl/sysx_job_scheduler.sv
// Two-requester round-robin job scheduler driving a sysX master register port:
// MOSI write, config write, busy poll with timeout, MISO read, completion pulse.
module sysx_job_scheduler #(
    parameter logic [15:0] pTimeout = 16'd1024
) (
    input  logic                  iClkA,
    input  logic                  iReset,
    sysx_job_scheduler_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE, WR_MOSI, WR_CFG, POLL, RD_MISO, DONE, ABORT
    } state_t;

    state_t      rState, sNext;
    logic        rPri, rOwner, sWinner;
    logic [1:0]  rCs;
    logic        rRx;
    logic [15:0] rCount;

    logic [1:0]  rGrant, rDone, sGrant, sDone;
    logic [31:0] rResult, rDataOut, sDataOut;
    logic        rTimeout, rBusy, rWrite, rEnable, sWrite, sEnable;
    logic [3:0]  rAddress, sAddress;

    assign sWinner = (bus.iReq == 2'b11) ? rPri : bus.iReq[1];

    always_ff @(posedge iClkA) begin
        if (iReset) rState <= IDLE;
        else        rState <= sNext;
    end

    always_comb begin
        sNext = rState;
        case (rState)
            IDLE:    if (bus.iReq != 2'b00) sNext = WR_MOSI;
            WR_MOSI: sNext = WR_CFG;
            WR_CFG:  sNext = POLL;
            POLL: begin
                if (rCount >= 16'd2 && !bus.iDataIn[0]) sNext = RD_MISO;
                else if (rCount == pTimeout)            sNext = ABORT;
            end
            RD_MISO: sNext = DONE;
            ABORT:   sNext = DONE;
            DONE:    sNext = IDLE;
            default: sNext = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with rState.
    always_comb begin
        sGrant   = '0;
        sDone    = '0;
        sAddress = '0;
        sDataOut = '0;
        sWrite   = 1'b0;
        sEnable  = 1'b0;
        case (sNext)
            WR_MOSI: begin
                sGrant[sWinner] = 1'b1;
                sAddress = 4'h1;
                sDataOut = sWinner ? bus.iData[63:32] : bus.iData[31:0];
                sWrite   = 1'b1;
                sEnable  = 1'b1;
            end
            WR_CFG: begin
                sAddress = 4'h0;
                sDataOut = {4'h0, bus.iClockStep, 8'h00, 3'b000, rRx, rCs, 2'b01};
                sWrite   = 1'b1;
                sEnable  = 1'b1;
            end
            POLL: begin
                sAddress = 4'h0;
                sEnable  = 1'b1;
            end
            RD_MISO: begin
                sAddress = 4'h2;
                sEnable  = 1'b1;
            end
            ABORT: begin
                sAddress = 4'h0;
                sWrite   = 1'b1;
                sEnable  = 1'b1;
            end
            DONE:    sDone[rOwner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge iClkA) begin
        if (iReset) begin
            rPri   <= 1'b0;
            rOwner <= 1'b0;
            rCs    <= '0;
            rRx    <= 1'b0;
            rCount <= '0;
        end else begin
            if (rState == IDLE && bus.iReq != 2'b00) begin
                rOwner <= sWinner;
                rCs    <= sWinner ? bus.iSelect[3:2] : bus.iSelect[1:0];
                rRx    <= bus.iReceive[sWinner];
            end
            if (rState == WR_CFG)
                rCount <= '0;
            else if (rState == POLL && sNext == POLL)
                rCount <= rCount + 16'd1;
            if (rState == DONE)
                rPri <= ~rOwner;
        end
    end

    always_ff @(posedge iClkA) begin
        if (iReset) begin
            rGrant   <= '0;
            rDone    <= '0;
            rResult  <= '0;
            rTimeout <= 1'b0;
            rBusy    <= 1'b0;
            rAddress <= '0;
            rDataOut <= '0;
            rWrite   <= 1'b0;
            rEnable  <= 1'b0;
        end else begin
            rGrant   <= sGrant;
            rDone    <= sDone;
            rBusy    <= (sNext != IDLE);
            rAddress <= sAddress;
            rDataOut <= sDataOut;
            rWrite   <= sWrite;
            rEnable  <= sEnable;
            if (rState == RD_MISO) begin
                rResult  <= bus.iDataIn;
                rTimeout <= 1'b0;
            end else if (rState == ABORT) begin
                rResult  <= 32'h0BADC0DE;
                rTimeout <= 1'b1;
            end
        end
    end

    assign bus.oGrant   = rGrant;
    assign bus.oDone    = rDone;
    assign bus.oResult  = rResult;
    assign bus.oTimeout = rTimeout;
    assign bus.oBusy    = rBusy;
    assign bus.oAddress = rAddress;
    assign bus.oDataOut = rDataOut;
    assign bus.oWrite   = rWrite;
    assign bus.oEnable  = rEnable;
endmodule
